// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency ROM and buffers {pc, word} in a prefetch FIFO.
// Optional feature macro: IFU_MISALIGN_TRAP_EN adds a sticky misalign_fault output that halts fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fetch_entry_t fifo_mem [DEPTH];

    logic         pop;
    logic         push;
    logic         issue;
    logic         fault_hold;
    logic [CW:0]  occupancy;

    // Credit check counts the read in flight so a returning word always has a free slot.
    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    always_comb begin
        pop       = instr_valid && instr_ready;
        push      = inflight && !redirect;
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue     = rst && !redirect && !fault_hold && (occupancy < DEPTH_C);
    end

    assign rom_en      = issue;
    assign rom_addr    = pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_mem[rd_ptr].word : 32'h0;
    assign instr_pc    = instr_valid ? fifo_mem[rd_ptr].pc   : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            // Redirect wins over any same-cycle push or pop; the returning word is dropped.
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count gates its visibility, and instr/instr_pc read 0 when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: req_pc, word: rom_rdata};
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_fault <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_fault <= 1'b1;
        end
    end

    assign fault_hold = misalign_fault;
`else
    // Target low bits are discarded silently when the trap is not built in.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fault_hold           = 1'b0;
`endif

endmodule
